// File: rtl/mips_pipe_pkg.sv
// Shared MEM->WB pipeline definitions: default field widths and the payload layout
// carried from the memory stage into write-back.
package mips_pipe_pkg;

   localparam int MEM_WB_DATA_W = 32;
   localparam int MEM_WB_DST_W  = 5;

   // Default-width payload; the register itself rebuilds this layout at its own widths.
   typedef struct packed {
      logic                     wb_en;
      logic                     mem_r_en;
      logic [MEM_WB_DATA_W-1:0] alu_result;
      logic [MEM_WB_DATA_W-1:0] mem_read_value;
      logic [MEM_WB_DST_W-1:0]  dst;
   } mem_wb_payload_t;

endpackage

// File: rtl/mem_wb_pipe_reg_sat_counter.sv
// Saturating up-counter with a synchronous clear that wins over increment.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] count
);

   // Count up on inc, stick at all-ones, clear on clr, async active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != {W{1'b1}})) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/mem_wb_pipe_reg.sv
// MEM->WB pipeline register with valid/ready handshake, optional skid entry,
// synchronous flush and a saturating count of stalled cycles.
module mem_wb_pipe_reg
   import mips_pipe_pkg::*;
#(
   parameter int DATA_W      = MEM_WB_DATA_W,
   parameter int DST_W       = MEM_WB_DST_W,
   parameter int SKID        = 1,
   parameter int STALL_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic                   in_wb_en,
   input  logic                   in_mem_r_en,
   input  logic [DATA_W-1:0]      in_alu_result,
   input  logic [DATA_W-1:0]      in_mem_read_value,
   input  logic [DST_W-1:0]       in_dst,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   out_wb_en,
   output logic                   out_mem_r_en,
   output logic [DATA_W-1:0]      out_alu_result,
   output logic [DATA_W-1:0]      out_mem_read_value,
   output logic [DST_W-1:0]       out_dst,
   input  logic                   stall_clr,
   output logic [STALL_CNT_W-1:0] stall_count
);

   typedef struct packed {
      logic              wb_en;
      logic              mem_r_en;
      logic [DATA_W-1:0] alu_result;
      logic [DATA_W-1:0] mem_read_value;
      logic [DST_W-1:0]  dst;
   } payload_t;

   payload_t in_pl_p0;
   payload_t m_pl_p1;
   payload_t s_pl_p1;
   logic     m_vld_p1;
   logic     s_vld_p1;
   logic     in_fire;
   logic     out_fire;
   logic     stall_inc;

   assign in_pl_p0 = {in_wb_en, in_mem_r_en, in_alu_result, in_mem_read_value, in_dst};

   // With a skid entry, in_ready depends only on a flop, cutting the ready path
   // back into the memory stage; without it, ready passes straight through.
   if (SKID != 0) begin : g_skid_ready
      assign in_ready = ~s_vld_p1;
   end else begin : g_pass_ready
      assign in_ready = out_ready | ~m_vld_p1;
   end

   assign in_fire  = in_valid & in_ready;
   assign out_fire = m_vld_p1 & out_ready;

   // ---- stage p1: main (M) and skid (S) entries; flush drops both, FIFO order kept ----
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_vld_p1 <= 1'b0;
         s_vld_p1 <= 1'b0;
         m_pl_p1  <= '0;
         s_pl_p1  <= '0;
      end else if (flush) begin
         m_vld_p1 <= 1'b0;
         s_vld_p1 <= 1'b0;
      end else if (SKID != 0) begin
         if (!m_vld_p1 || out_fire) begin
            // M is free this edge: the older skid beat moves up first.
            if (s_vld_p1) begin
               m_pl_p1  <= s_pl_p1;
               m_vld_p1 <= 1'b1;
               if (in_fire) begin
                  s_pl_p1 <= in_pl_p0;
               end
               s_vld_p1 <= in_fire;
            end else begin
               if (in_fire) begin
                  m_pl_p1 <= in_pl_p0;
               end
               m_vld_p1 <= in_fire;
               s_vld_p1 <= 1'b0;
            end
         end else if (in_fire) begin
            // M is stalled: park the new beat in S.
            s_pl_p1  <= in_pl_p0;
            s_vld_p1 <= 1'b1;
         end
      end else begin
         if (in_fire) begin
            m_pl_p1  <= in_pl_p0;
            m_vld_p1 <= 1'b1;
         end else if (out_fire) begin
            m_vld_p1 <= 1'b0;
         end
         s_vld_p1 <= 1'b0;
      end
   end

   // Outputs come straight from M, so they are bit-stable while stalled; the
   // enables are masked so a flushed, stale payload can never write back.
   assign out_valid          = m_vld_p1;
   assign out_wb_en          = m_pl_p1.wb_en & m_vld_p1;
   assign out_mem_r_en       = m_pl_p1.mem_r_en & m_vld_p1;
   assign out_alu_result     = m_pl_p1.alu_result;
   assign out_mem_read_value = m_pl_p1.mem_read_value;
   assign out_dst            = m_pl_p1.dst;

   // A cycle counts as stalled whenever M holds a beat that downstream refuses,
   // including a flush cycle.
   assign stall_inc = m_vld_p1 & ~out_ready;

   sat_counter #(
      .W (STALL_CNT_W)
   ) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (stall_inc),
      .clr   (stall_clr),
      .count (stall_count)
   );

endmodule
